// File: rtl/pipelined_carry_select_adder.sv
// rtl/pipelined_carry_select_adder.sv - pipelined carry-select adder/subtractor with valid/ready flow
// Each stage resolves a contiguous group of carry-select blocks and passes the block carry onward.
module pipelined_carry_select_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4,
  parameter int STAGES      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic                  carry_i,
  input  logic                  subtract_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int BW_SAFE    = (BLOCK_WIDTH < 1) ? 1 : BLOCK_WIDTH;
  localparam int ST_SAFE    = (STAGES < 1) ? 1 : STAGES;
  localparam int CSA_BLOCKS = DATA_WIDTH / BW_SAFE;
  localparam int BPS        = (CSA_BLOCKS / ST_SAFE < 1) ? 1 : CSA_BLOCKS / ST_SAFE;

  if (BLOCK_WIDTH < 1 || STAGES < 1 || (DATA_WIDTH % BW_SAFE) != 0 ||
      CSA_BLOCKS < 1 || (CSA_BLOCKS % ST_SAFE) != 0) begin : g_bad_params
    $error("pipelined_carry_select_adder: illegal DATA_WIDTH/BLOCK_WIDTH/STAGES combination");
  end

  logic                  w_advance;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic                  w_c_eff;

  logic [DATA_WIDTH-1:0] w_q_a     [ST_SAFE];
  logic [DATA_WIDTH-1:0] w_q_b     [ST_SAFE];
  logic [DATA_WIDTH-1:0] w_q_sum   [ST_SAFE];
  logic                  w_q_carry [ST_SAFE];
  logic                  w_q_valid [ST_SAFE];

  assign w_b_eff   = subtract_i ? ~operand_B_i : operand_B_i;
  assign w_c_eff   = subtract_i ? 1'b1 : carry_i;
  assign w_advance = ready_i | ~valid_o;
  assign ready_o   = w_advance;

  for (genvar k = 0; k < ST_SAFE; k++) begin : g_stage
    logic [DATA_WIDTH-1:0]         w_a_in;
    logic [DATA_WIDTH-1:0]         w_b_in;
    logic [DATA_WIDTH-1:0]         w_sum_in;
    logic                          w_carry_in;
    logic                          w_valid_in;
    logic [BPS-1:0][BW_SAFE:0]     w_blk;
    logic [BPS:0]                  w_c;
    logic [DATA_WIDTH-1:0]         w_sum_next;

    logic [DATA_WIDTH-1:0]         r_a;
    logic [DATA_WIDTH-1:0]         r_b;
    logic [DATA_WIDTH-1:0]         r_sum;
    logic                          r_carry;
    logic                          r_valid;

    if (k == 0) begin : g_head
      assign w_a_in     = operand_A_i;
      assign w_b_in     = w_b_eff;
      assign w_sum_in   = '0;
      assign w_carry_in = w_c_eff;
      assign w_valid_in = valid_i;
    end else begin : g_body
      assign w_a_in     = w_q_a[k-1];
      assign w_b_in     = w_q_b[k-1];
      assign w_sum_in   = w_q_sum[k-1];
      assign w_carry_in = w_q_carry[k-1];
      assign w_valid_in = w_q_valid[k-1];
    end

    assign w_c[0] = w_carry_in;

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      localparam int LSB = (k * BPS + j) * BW_SAFE;
      if (k == 0 && j == 0) begin : g_ripple
        assign w_blk[j] = {1'b0, w_a_in[LSB +: BW_SAFE]} + {1'b0, w_b_in[LSB +: BW_SAFE]}
                        + {{BW_SAFE{1'b0}}, w_c[j]};
      end else begin : g_select
        logic [BW_SAFE:0] w_s0;
        logic [BW_SAFE:0] w_s1;
        // (a+b)+1 cannot exceed BW_SAFE+1 bits, so it is the exact carry-in-1 sum
        assign w_s0     = {1'b0, w_a_in[LSB +: BW_SAFE]} + {1'b0, w_b_in[LSB +: BW_SAFE]};
        assign w_s1     = w_s0 + {{BW_SAFE{1'b0}}, 1'b1};
        assign w_blk[j] = w_c[j] ? w_s1 : w_s0;
      end
      assign w_c[j+1] = w_blk[j][BW_SAFE];
    end

    always_comb begin
      w_sum_next = w_sum_in;
      for (int j = 0; j < BPS; j++) begin
        w_sum_next[(k * BPS + j) * BW_SAFE +: BW_SAFE] = w_blk[j][BW_SAFE-1:0];
      end
    end

    // Flush clears valid even when stalled; data may go stale.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_a     <= '0;
        r_b     <= '0;
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        if (w_advance) begin
          r_a     <= w_a_in;
          r_b     <= w_b_in;
          r_sum   <= w_sum_next;
          r_carry <= w_c[BPS];
        end
        if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_advance) begin
          r_valid <= w_valid_in;
        end
      end
    end

    assign w_q_a[k]     = r_a;
    assign w_q_b[k]     = r_b;
    assign w_q_sum[k]   = r_sum;
    assign w_q_carry[k] = r_carry;
    assign w_q_valid[k] = r_valid;
  end

  assign result_o   = w_q_sum[ST_SAFE-1];
  assign carry_o    = w_q_carry[ST_SAFE-1];
  assign valid_o    = w_q_valid[ST_SAFE-1];
  assign overflow_o = (w_q_a[ST_SAFE-1][DATA_WIDTH-1] == w_q_b[ST_SAFE-1][DATA_WIDTH-1]) &
                      (w_q_sum[ST_SAFE-1][DATA_WIDTH-1] != w_q_a[ST_SAFE-1][DATA_WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb/tb_pipelined_carry_select_adder.sv - directed and multi-configuration checks of the pipelined adder
module tb_pipelined_carry_select_adder;

  function automatic int cfg_dw(input int i);
    case (i)
      0: return 16;
      1: return 32;
      2: return 64;
      3: return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_bw(input int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 4;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_st(input int i);
    case (i)
      0: return 8;
      1: return 1;
      2: return 4;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  localparam int NCFG = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        vin;
  logic        rdy_in;
  logic        rdy_out;
  logic [31:0] res;
  logic        co;
  logic        ov;
  logic        vout;

  logic        rnd_rst_n;
  logic [63:0] rnd_a;
  logic [63:0] rnd_b;
  logic        rnd_cin;
  logic        rnd_sub;
  logic        rnd_vin;
  logic        rnd_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_carry_select_adder #(
    .DATA_WIDTH(32), .BLOCK_WIDTH(4), .STAGES(2)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .operand_A_i(a), .operand_B_i(b), .carry_i(cin), .subtract_i(sub),
    .valid_i(vin), .ready_o(rdy_out), .result_o(res), .carry_o(co),
    .overflow_o(ov), .valid_o(vout), .ready_i(rdy_in)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic c,
                       input logic [31:0] x, input logic [31:0] y);
    vin = v;
    sub = s;
    cin = c;
    a   = x;
    b   = y;
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic c, input logic o);
    check_eq({tag, "_valid"}, vout, 1'b1);
    check_eq({tag, "_result"}, res, r);
    check_eq({tag, "_carry"}, co, c);
    check_eq({tag, "_ovf"}, ov, o);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = cfg_dw(g);
    logic [W-1:0] r_res;
    logic         r_co;
    logic         r_ov;
    logic         r_vo;
    logic         r_ro;
    logic [W+1:0] q[$];
    logic [W+1:0] exp_v;
    int           n_pop = 0;

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic c);
      logic [W-1:0] be;
      logic [W:0]   full;
      logic         o;
      be   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
      o    = (x[W-1] == be[W-1]) && (full[W-1] != x[W-1]);
      return {o, full[W], full[W-1:0]};
    endfunction

    pipelined_carry_select_adder #(
      .DATA_WIDTH(W), .BLOCK_WIDTH(cfg_bw(g)), .STAGES(cfg_st(g))
    ) u_cfg (
      .clk_i(clk), .rst_n_i(rnd_rst_n), .flush_i(1'b0),
      .operand_A_i(rnd_a[W-1:0]), .operand_B_i(rnd_b[W-1:0]),
      .carry_i(rnd_cin), .subtract_i(rnd_sub),
      .valid_i(rnd_vin), .ready_o(r_ro), .result_o(r_res), .carry_o(r_co),
      .overflow_o(r_ov), .valid_o(r_vo), .ready_i(1'b1)
    );

    initial begin
      forever begin
        @(posedge clk);
        if (rnd_rst_n && rnd_vin) q.push_back(model(rnd_a[W-1:0], rnd_b[W-1:0], rnd_sub, rnd_cin));
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (r_vo) begin
          if (q.size() == 0) begin
            check_eq("rand_spurious", 1'b1, 1'b0);
          end else begin
            exp_v = q.pop_front();
            check_eq("rand_cfg", {r_ov, r_co, r_res}, exp_v);
            n_pop++;
          end
        end
      end
    end

    initial begin
      wait (rnd_done);
      check_eq("rand_drain", q.size(), 0);
      check_eq("rand_seen", n_pop > 50, 1'b1);
      check_eq("rand_ready", r_ro, 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; rdy_in = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rnd_rst_n = 1'b0; rnd_a = '0; rnd_b = '0; rnd_cin = 1'b0; rnd_sub = 1'b0;
    rnd_vin = 1'b0; rnd_done = 1'b0;

    tick(); tick();
    check_eq("rst_valid", vout, 1'b0);
    check_eq("rst_result", res, 32'h0);
    check_eq("rst_carry", co, 1'b0);
    check_eq("rst_ovf", ov, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", rdy_out, 1'b1);
    check_eq("post_rst_valid", vout, 1'b0);

    // add wraps to zero with carry out
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    check_eq("lat_one_cycle", vout, 1'b0);
    vin = 1'b0;
    tick();
    check_out("add_wrap", 32'h0000_0000, 1'b1, 1'b0);
    tick();
    check_eq("bubble_after_add", vout, 1'b0);

    // subtract with signed overflow; carry_i must be ignored
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
    tick();
    vin = 1'b0;
    tick();
    check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    drive(1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000);
    tick();
    vin = 1'b0;
    tick();
    check_out("add_cin_ovf", 32'h8000_0000, 1'b0, 1'b1);

    // stall: three back-to-back adds, downstream not ready for two cycles
    drive(1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111);
    tick();
    check_out("stall_t0_first", 32'h0001_0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hF000_0000, 32'h2000_0000);
    rdy_in = 1'b0;
    tick();
    check_out("stall_hold1", 32'h0001_0000, 1'b0, 1'b0);
    check_eq("stall_ready1", rdy_out, 1'b0);
    tick();
    check_out("stall_hold2", 32'h0001_0000, 1'b0, 1'b0);
    check_eq("stall_ready2", rdy_out, 1'b0);
    rdy_in = 1'b1;
    tick();
    check_out("stall_t1", 32'h2345_6789, 1'b0, 1'b0);
    vin = 1'b0;
    tick();
    check_out("stall_t2", 32'h1000_0000, 1'b1, 1'b0);
    tick();
    check_eq("stall_no_dup", vout, 1'b0);

    // flush with two in flight plus one discarded input
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0004);
    tick();
    check_out("pre_flush", 32'h0000_0003, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006);
    flush = 1'b1;
    tick();
    check_eq("flush_cycle1", vout, 1'b0);
    flush = 1'b0;
    vin = 1'b0;
    tick();
    check_eq("flush_cycle2", vout, 1'b0);
    tick();
    check_eq("flush_cycle3", vout, 1'b0);

    // asynchronous reset mid-stream
    drive(1'b1, 1'b0, 1'b0, 32'h9000_0000, 32'h9000_0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020);
    tick();
    check_out("pre_reset", 32'h2000_0000, 1'b1, 1'b1);
    vin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", vout, 1'b0);
    check_eq("async_rst_result", res, 32'h0);
    check_eq("async_rst_carry", co, 1'b0);
    check_eq("async_rst_ovf", ov, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("after_rst_valid", vout, 1'b0);
      check_eq("after_rst_ready", rdy_out, 1'b1);
    end

    drive(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006);
    tick();
    vin = 1'b0;
    tick();
    check_out("after_rst_add", 32'h0000_000B, 1'b0, 1'b0);

    // random operands across several widths and stage counts
    rnd_rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      rnd_a   = {$urandom(), $urandom()};
      rnd_b   = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) rnd_a = '1;
      if ($urandom_range(0, 7) == 0) rnd_b = {1'b1, 63'h0};
      rnd_sub = $urandom_range(0, 1) == 1;
      rnd_cin = $urandom_range(0, 1) == 1;
      rnd_vin = $urandom_range(0, 3) != 0;
    end
    tick();
    rnd_vin = 1'b0;
    repeat (12) tick();
    rnd_done = 1'b1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_select_adder.md
PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter BLOCK_WIDTH, default 4: bits per carry-select block.
REQ-003 The block SHALL have parameter STAGES, default 2: number of register stages, i.e. latency in cycles.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous pipeline flush.
REQ-007 The block SHALL have port operand_A_i, input, DATA_WIDTH bits: first operand.
REQ-008 The block SHALL have port operand_B_i, input, DATA_WIDTH bits: second operand.
REQ-009 The block SHALL have port carry_i, input, 1 bit: carry-in, used in add mode only.
REQ-010 The block SHALL have port subtract_i, input, 1 bit: 1 = A - B, 0 = A + B + carry_i.
REQ-011 The block SHALL have port valid_i, input, 1 bit: input transaction valid.
REQ-012 The block SHALL have port ready_o, output, 1 bit: block can accept an input this cycle.
REQ-013 The block SHALL have port result_o, output, DATA_WIDTH bits: sum or difference.
REQ-014 The block SHALL have port carry_o, output, 1 bit: carry-out of the MSB; in subtract mode 1 = no borrow.
REQ-015 The block SHALL have port overflow_o, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port valid_o, output, 1 bit: output transaction valid.
REQ-017 The block SHALL have port ready_i, input, 1 bit: downstream accepts the output.

Function
REQ-018 DATA_WIDTH SHALL be a multiple of BLOCK_WIDTH, and CSA_BLOCKS = DATA_WIDTH/BLOCK_WIDTH SHALL be a multiple of STAGES with STAGES >= 1; other values SHALL be a elaboration error.
REQ-019 The effective B SHALL be ~operand_B_i when subtract_i = 1, else operand_B_i; the effective carry-in SHALL be 1 when subtract_i = 1, else carry_i.
REQ-020 Block 0 SHALL be a ripple adder; every other block SHALL compute both carry-in-0 and carry-in-1 sums and select with the incoming block carry.
REQ-021 Stage k (0..STAGES-1) SHALL compute blocks k*CSA_BLOCKS/STAGES .. (k+1)*CSA_BLOCKS/STAGES-1 and register the partial result, the block carry, the unconsumed operand slices, and its valid bit.
REQ-022 Pipeline advance SHALL be advance = ready_i | ~valid_o; ready_o SHALL equal advance combinationally.
REQ-023 When advance = 1, all stages SHALL shift by one and stage 0 SHALL capture the inputs with valid = valid_i; when advance = 0, all stage registers SHALL hold.
REQ-024 An input SHALL be accepted only on valid_i & ready_o, and its result SHALL appear on valid_o exactly STAGES cycles later if advance stays 1 throughout.
REQ-025 Bubbles SHALL NOT be collapsed: an invalid slot occupies a stage like a valid one.
REQ-026 result_o, carry_o, overflow_o SHALL be driven from final-stage registers and SHALL be stable while valid_o = 1 and ready_i = 0.
REQ-027 overflow_o SHALL be (A[MSB] == Beff[MSB]) & (result[MSB] != A[MSB]), computed from the registered MSB values of the final block.
REQ-028 flush_i = 1 SHALL clear every stage valid bit at the next edge, regardless of ready_i; data registers MAY keep stale values; an input presented in the same cycle SHALL be discarded.
REQ-029 Result width SHALL be DATA_WIDTH; the carry out of the MSB SHALL appear only on carry_o (no wrap into result).

Reset
REQ-030 On rst_n_i = 0, all valid bits, result_o, carry_o and overflow_o SHALL go to 0 immediately, independent of clk_i.
REQ-031 After reset release, ready_o SHALL be 1 and valid_o SHALL stay 0 until the first accepted input has traversed STAGES stages.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight transactions without producing any valid_o.

Verification
REQ-033 The bench SHALL apply add A=0xFFFFFFFF, B=0x00000001, carry_i=0, with ready_i=1 -> 2 cycles later result_o=0x00000000, carry_o=1, overflow_o=0, valid_o=1.
REQ-034 The bench SHALL apply subtract A=0x80000000, B=0x00000001 -> result_o=0x7FFFFFFF, carry_o=1, overflow_o=1.
REQ-035 The bench SHALL stream 3 back-to-back adds with ready_i=0 from cycle 2 to cycle 4 -> valid_o held with constant outputs, ready_o=0, and no transaction lost or duplicated after ready_i returns.
REQ-036 The bench SHALL assert flush_i with 2 transactions in flight -> valid_o=0 on the next 2 cycles.
REQ-037 The bench SHALL assert rst_n_i low asynchronously mid-stream -> all outputs 0 before the next clock edge, and ready_o=1 after release.
REQ-038 The bench SHALL run random operands across STAGES in {1,2,4,8}, BLOCK_WIDTH in {2,4}, DATA_WIDTH in {16,32,64} -> results match a reference sum or difference with correct carry and overflow.
